// File: rtl/ss_sequencer.sv
// Save-state bus master: walks every ssbus slave, streaming headered register
// images into a buffer memory on save and writing them back on load.
module ss_sequencer #(
  parameter int unsigned NUM_SLAVES = 32,
  parameter int unsigned BUF_AW     = 20,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_save,
  input  logic              start_load,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [7:0]        ss_select,
  output logic              ss_query,
  output logic              ss_read,
  output logic              ss_write,
  output logic [23:0]       ss_addr,
  output logic [63:0]       ss_wdata,
  input  logic              ss_ack,
  input  logic [63:0]       ss_rdata,
  input  logic [23:0]       ss_count,
  output logic              buf_req,
  output logic              buf_we,
  output logic [BUF_AW-1:0] buf_addr,
  output logic [63:0]       buf_wdata,
  input  logic [63:0]       buf_rdata,
  input  logic              buf_ack
);

  localparam logic [3:0] StIdle    = 4'd0;
  localparam logic [3:0] StQuery   = 4'd1;
  localparam logic [3:0] StSaveHdr = 4'd2;
  localparam logic [3:0] StSaveRd  = 4'd3;
  localparam logic [3:0] StSaveWr  = 4'd4;
  localparam logic [3:0] StLoadHdr = 4'd5;
  localparam logic [3:0] StLoadRd  = 4'd6;
  localparam logic [3:0] StLoadWr  = 4'd7;
  localparam logic [3:0] StNext    = 4'd8;
  localparam logic [3:0] StFinish  = 4'd9;
  localparam logic [3:0] StFail    = 4'd10;

  localparam logic [15:0] Magic      = 16'hA55A;
  localparam logic [63:0] Terminator = 64'hA55A_FFFF_0000_0000;
  localparam int unsigned TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [3:0]        r_state;
  logic              r_load;
  logic              r_active;
  logic [7:0]        r_slave;
  logic [23:0]       r_reg;
  logic [23:0]       r_count;
  logic [63:0]       r_data;
  logic [BUF_AW-1:0] r_buf_addr;
  logic [TW-1:0]     r_tmo;
  logic              r_busy;
  logic              r_done;
  logic              r_error;

  logic              w_slave_acc;
  logic              w_buf_acc;
  logic              w_ack;
  logic [63:0]       w_header;
  logic [BUF_AW:0]   w_addr_inc;
  logic              w_addr_ovf;
  logic [23:0]       w_reg_inc;
  logic              w_last;
  logic [8:0]        w_slave_inc;
  logic              w_slave_end;
  logic              w_hdr_ok;

  assign w_slave_acc = r_active & ((r_state == StQuery) | (r_state == StSaveRd) |
                                   (r_state == StLoadWr));
  assign w_buf_acc   = r_active & ((r_state == StSaveHdr) | (r_state == StSaveWr) |
                                   (r_state == StLoadHdr) | (r_state == StLoadRd) |
                                   (r_state == StFinish));
  assign w_ack       = w_slave_acc ? ss_ack : (w_buf_acc & buf_ack);
  assign w_header    = {Magic, 8'h00, r_slave, r_count, 8'h00};
  assign w_addr_inc  = {1'b0, r_buf_addr} + 1'b1;
  assign w_addr_ovf  = w_addr_inc[BUF_AW];
  assign w_reg_inc   = r_reg + 24'd1;
  assign w_last      = (w_reg_inc == r_count);
  assign w_slave_inc = {1'b0, r_slave} + 9'd1;
  assign w_slave_end = (w_slave_inc == 9'(NUM_SLAVES));
  // Reserved zero fields of the header are not checked on load.
  assign w_hdr_ok    = (buf_rdata[63:48] == Magic) && (buf_rdata[39:32] == r_slave) &&
                       (buf_rdata[31:8] == r_count);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= StIdle;
      r_load     <= 1'b0;
      r_active   <= 1'b0;
      r_slave    <= '0;
      r_reg      <= '0;
      r_count    <= '0;
      r_data     <= '0;
      r_buf_addr <= '0;
      r_tmo      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (start_save || start_load) begin
            r_load     <= ~start_save;
            r_busy     <= 1'b1;
            r_error    <= 1'b0;
            r_buf_addr <= '0;
            r_slave    <= '0;
            r_reg      <= '0;
            r_active   <= 1'b0;
            r_state    <= StQuery;
          end
        end
        StNext: begin
          r_slave <= w_slave_inc[7:0];
          r_state <= w_slave_end ? StFinish : StQuery;
        end
        StFail: begin
          r_error <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        StQuery, StSaveHdr, StSaveRd, StSaveWr, StLoadHdr, StLoadRd, StLoadWr, StFinish: begin
          // Each access state idles one cycle, then holds its strobe until ack.
          if (!r_active) begin
            r_active <= 1'b1;
            r_tmo    <= '0;
          end else if (w_ack) begin
            r_active <= 1'b0;
            case (r_state)
              StQuery: begin
                if (ss_count == 24'd0) begin
                  r_state <= StNext;
                end else begin
                  r_count <= ss_count;
                  r_state <= r_load ? StLoadHdr : StSaveHdr;
                end
              end
              StSaveHdr, StLoadHdr: begin
                if (w_addr_ovf || (r_load && !w_hdr_ok)) begin
                  r_state <= StFail;
                end else begin
                  r_buf_addr <= w_addr_inc[BUF_AW-1:0];
                  r_reg      <= '0;
                  r_state    <= r_load ? StLoadRd : StSaveRd;
                end
              end
              StSaveRd: begin
                r_data  <= ss_rdata;
                r_state <= StSaveWr;
              end
              StSaveWr: begin
                if (w_addr_ovf) begin
                  r_state <= StFail;
                end else begin
                  r_buf_addr <= w_addr_inc[BUF_AW-1:0];
                  r_reg      <= w_reg_inc;
                  r_state    <= w_last ? StNext : StSaveRd;
                end
              end
              StLoadRd: begin
                r_data <= buf_rdata;
                if (w_addr_ovf) begin
                  r_state <= StFail;
                end else begin
                  r_buf_addr <= w_addr_inc[BUF_AW-1:0];
                  r_state    <= StLoadWr;
                end
              end
              StLoadWr: begin
                r_reg   <= w_reg_inc;
                r_state <= w_last ? StNext : StLoadRd;
              end
              default: begin
                if (r_load && (buf_rdata != Terminator)) begin
                  r_state <= StFail;
                end else begin
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= StIdle;
                end
              end
            endcase
          end else if (r_tmo == TW'(TIMEOUT - 1)) begin
            r_active <= 1'b0;
            r_state  <= StFail;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;
  assign ss_select = r_slave;
  assign ss_query  = r_active & (r_state == StQuery);
  assign ss_read   = r_active & (r_state == StSaveRd);
  assign ss_write  = r_active & (r_state == StLoadWr);
  assign ss_addr   = r_reg;
  assign ss_wdata  = r_data;
  assign buf_req   = w_buf_acc;
  assign buf_we    = (r_state == StSaveHdr) | (r_state == StSaveWr) |
                     ((r_state == StFinish) & ~r_load);
  assign buf_addr  = r_buf_addr;
  assign buf_wdata = (r_state == StSaveHdr) ? w_header :
                     (r_state == StFinish)  ? Terminator : r_data;

endmodule
